// File: rtl/histogram_pkg.sv
// histogram_pkg: shared constants and FSM encoding for the histogram streamer.
//   HIST_ADDR_W   - default bin address width
//   HIST_DATA_W   - default bin count width
//   HIST_READ_LAT - default memory read latency
//   hist_state_e  - streamer FSM states
//   ptr_w()       - pointer width for a FIFO of a given depth (min 1 bit)
package histogram_pkg;

  localparam int HIST_ADDR_W   = 10;
  localparam int HIST_DATA_W   = 16;
  localparam int HIST_READ_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hist_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: small synchronous FIFO used as the output skid buffer.
// The head word is presented combinationally and stays put until popped.
// Ports:
//   clk, reset   - clock, synchronous active-low reset (flushes contents)
//   i_push/i_din - write a word (caller guarantees not full)
//   i_pop        - downstream ready; pops the head when o_valid
//   o_valid      - FIFO non-empty
//   o_dout       - head word
//   o_count      - current occupancy
module stream_skid_fifo
  import histogram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign o_valid = (r_cnt != '0);
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/histogram_streamer.sv
// histogram_streamer: streams a range of histogram bins out of a fixed-latency
// memory as a valid/ready word stream, with credit-based flow control so the
// skid FIFO can never overflow.
// Build option: HISTOGRAM_STREAMER_CLEAR_EN - zero each bin in memory in the
//   cycle its read data is captured (read-and-clear dump).
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   start                - one-cycle dump request (honoured in IDLE only)
//   first_bin, bin_count - dump range; bin_count 0 means all 2^ADDR_W bins
//   mem_addr/we/wdata    - memory port out; mem_rdata returns READ_LAT later
//   out_valid/ready      - stream handshake
//   out_data/bin/last    - bin count, its index, final-word marker
//   busy, done           - dump in progress / one-cycle completion pulse
module histogram_streamer
  import histogram_pkg::*;
#(
  parameter int ADDR_W     = HIST_ADDR_W,
  parameter int DATA_W     = HIST_DATA_W,
  parameter int READ_LAT   = HIST_READ_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_bin,
  input  logic [ADDR_W:0]   bin_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_bin,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(READ_LAT+1);
  localparam int OW = $clog2(FIFO_DEPTH+READ_LAT+1) + 1;
  localparam int FW = DATA_W + ADDR_W + 1;

  hist_state_e r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_left;   // reads still to issue
  logic              r_busy, r_done;

  // tags travel alongside the memory read so the captured word knows its bin
  logic [READ_LAT:1]             r_vld_pipe;
  logic [READ_LAT:1]             r_last_pipe;
  logic [READ_LAT:1][ADDR_W-1:0] r_bin_pipe;

  logic              w_cap, w_cap_last, w_clr, w_issue, w_credit_ok, w_last_xfer;
  logic [ADDR_W-1:0] w_cap_bin;
  logic [CW-1:0]     w_fifo_cnt;
  logic [IW-1:0]     w_inflight;
  logic [FW-1:0]     w_fifo_dout;

  assign w_cap      = r_vld_pipe[READ_LAT];
  assign w_cap_bin  = r_bin_pipe[READ_LAT];
  assign w_cap_last = r_last_pipe[READ_LAT];
  assign w_inflight = IW'($countones(r_vld_pipe));

  // a word still in flight already owns a FIFO slot
  assign w_credit_ok = (OW'(w_fifo_cnt) + OW'(w_inflight)) < OW'(FIFO_DEPTH);

`ifdef HISTOGRAM_STREAMER_CLEAR_EN
  // the port is busy writing the cleared bin back, so no read this cycle
  assign w_clr  = w_cap;
  assign mem_we = w_clr && reset;
`else
  assign w_clr  = 1'b0;
  assign mem_we = 1'b0;
`endif

  assign w_issue   = (r_state == ISSUE) && w_credit_ok && !w_clr;
  assign mem_wdata = '0;

  // gated by reset so nothing reaches memory while reset is held
  always_comb begin
    mem_addr = '0;
    if (reset) begin
      if (w_clr)        mem_addr = w_cap_bin;
      else if (w_issue) mem_addr = r_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= w_issue;
      for (int k = 2; k <= READ_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_bin_pipe[1]  <= r_addr;
    r_last_pipe[1] <= (r_left == (ADDR_W+1)'(1));
    for (int k = 2; k <= READ_LAT; k++) begin
      r_bin_pipe[k]  <= r_bin_pipe[k-1];
      r_last_pipe[k] <= r_last_pipe[k-1];
    end
  end

  stream_skid_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_cap),
    .i_din   ({w_cap_last, w_cap_bin, mem_rdata}),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_cnt)
  );

  assign {out_last, out_bin, out_data} = w_fifo_dout;
  assign w_last_xfer = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_left  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr  <= first_bin;
            r_left  <= (bin_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : bin_count;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - (ADDR_W+1)'(1);
            if (r_left == (ADDR_W+1)'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // leaving on the last transfer makes done land the very next cycle;
          // the empty check covers anything that empties without a last word
          if (w_last_xfer || (w_fifo_cnt == '0 && w_inflight == '0)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
